// File: rtl/key_event_scheduler.sv
// key_event_scheduler: debounced multi-key front end whose per-key
// pending press/release events are delivered round-robin over valid/ready.
module key_event_scheduler #(
   parameter int N_KEYS = 4,
   parameter int SAMPLE_PERIOD = 5000,
   parameter int STABLE_SAMPLES = 10,
   localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1,
   localparam int CW = $clog2(STABLE_SAMPLES + 1),
   localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_state,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [KW-1:0]     evt_key,
   output logic              evt_press,
   output logic [N_KEYS-1:0] overrun,
   input  logic              clr_overrun
);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t              state;
   state_t              state_n;
   logic [N_KEYS-1:0]   s1;
   logic [N_KEYS-1:0]   s2;
   logic [TW-1:0]       tcnt;
   logic                tick;
   logic [CW-1:0]       cnt [N_KEYS];
   logic [N_KEYS-1:0]   raise;
   logic [N_KEYS-1:0]   pend;
   logic [N_KEYS-1:0]   ptype;
   logic [N_KEYS-1:0]   clr_pend;
   logic [2*N_KEYS-1:0] dbl;
   logic [N_KEYS-1:0]   rot;
   logic [KW-1:0]       ptr;
   logic [KW-1:0]       sel;
   logic                found;
   logic                grant;
   logic                accept;

   function automatic logic [KW-1:0] wrap_add(input logic [KW-1:0] a,
                                              input int b);
      int s;
      s = int'(a) + b;
      if (s >= N_KEYS) s = s - N_KEYS;
      return KW'(s);
   endfunction

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= key_in;
         s2 <= s1;
      end
   end

   assign tick = (tcnt == TW'(SAMPLE_PERIOD - 1));

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) tcnt <= '0;
      else       tcnt <= tick ? '0 : tcnt + 1'b1;
   end

   always_comb begin
      raise = '0;
      for (int k = 0; k < N_KEYS; k++)
         raise[k] = (s2[k] != key_state[k]) && tick &&
                    (cnt[k] == CW'(STABLE_SAMPLES - 1));
   end

   // Any cycle that agrees with the accepted level restarts the count.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int k = 0; k < N_KEYS; k++) cnt[k] <= '0;
         key_state <= '0;
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            if (s2[k] == key_state[k] || raise[k]) cnt[k] <= '0;
            else if (tick)                         cnt[k] <= cnt[k] + 1'b1;
         end
         key_state <= key_state ^ raise;
      end
   end

   assign dbl = {pend, pend} >> ptr;
   assign rot = dbl[N_KEYS-1:0];

   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            sel   = wrap_add(ptr, i);
         end
      end
   end

   assign grant    = (state == IDLE) && (|pend);
   assign accept   = (state == OFFER) && evt_ready;
   assign clr_pend = grant ? (N_KEYS'(1) << sel) : '0;

   // A fresh event for the key being granted simply re-arms its slot.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         pend    <= '0;
         ptype   <= '0;
         overrun <= '0;
      end else begin
         pend    <= (pend & ~clr_pend) | raise;
         ptype   <= (ptype & ~raise) | (s2 & raise);
         overrun <= (clr_overrun ? '0 : overrun) |
                    (raise & pend & ~clr_pend);
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (|pend) state_n = OFFER;
         OFFER:   if (evt_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      evt_valid = (state == OFFER);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         evt_key   <= '0;
         evt_press <= 1'b0;
         ptr       <= '0;
      end else begin
         if (grant) begin
            evt_key   <= sel;
            evt_press <= ptype[sel];
         end
         if (accept) ptr <= wrap_add(evt_key, 1);
      end
   end

endmodule
